// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register.
// A grant loads the register and pulses ack for one cycle, then a HOLD cycle follows.
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic [IW-1:0]         q_owner,
    output logic                  q_valid
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [IW-1:0]     q_owner_q, q_owner_d;
    logic              q_valid_q, q_valid_d;
    logic [NREQ-1:0]   ack_q, ack_d;

    logic              found;
    logic [IW-1:0]     win;

    // Rotating scan starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        q_d       = q_q;
        q_owner_d = q_owner_q;
        q_valid_d = q_valid_q;
        ack_d     = '0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    q_d       = '0;
                    q_valid_d = 1'b0;
                end else if (found) begin
                    q_d        = wdata[win*WIDTH +: WIDTH];
                    q_owner_d  = win;
                    q_valid_d  = 1'b1;
                    ack_d[win] = 1'b1;
                    rr_ptr_d   = win;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // Requests are ignored here; the owner sees ack and drops req.
                if (clr) begin
                    q_d       = '0;
                    q_valid_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IW'(NREQ - 1);
            q_q       <= '0;
            q_owner_q <= '0;
            q_valid_q <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            q_q       <= q_d;
            q_owner_q <= q_owner_d;
            q_valid_q <= q_valid_d;
            ack_q     <= ack_d;
        end
    end

    assign ack     = ack_q;
    assign q       = q_q;
    assign q_owner = q_owner_q;
    assign q_valid = q_valid_q;

endmodule
